mcpu_ram_controller: RTL and testbench



---
 rtl/mcpu_ram_controller.sv | 88 ++++++++
 tb/tb_mcpu_ram_controller.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mcpu_ram_controller.sv
// mcpu_ram_controller
//   Shared data/instruction RAM for the MicroCPU. A single storage array
//   serves two read ports, so instruction fetch observes data-port writes.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset (clears read registers only)
//   we         : data-port write enable
//   datawr     : data-port write data
//   re         : data-port read enable
//   addr       : data-port address, shared by read and write
//   datard     : data-port read data, registered, 1-cycle latency
//   instraddr  : instruction-port address
//   instrrd    : instruction-port read data, registered, 1-cycle latency
module mcpu_ram_controller #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_SIZE   = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [WORD_SIZE-1:0]  datawr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [WORD_SIZE-1:0]  datard,
  input  logic [ADDR_WIDTH-1:0] instraddr,
  output logic [WORD_SIZE-1:0]  instrrd
);

  // Storage is intentionally left out of reset so contents survive rst_n.
  logic [WORD_SIZE-1:0] mem [RAM_SIZE];

  logic                 addr_ok;
  logic                 iaddr_ok;
  logic                 wr_hit;
  logic [WORD_SIZE-1:0] datard_d, datard_q;
  logic [WORD_SIZE-1:0] instrrd_d, instrrd_q;

  // Addresses beyond the populated range never wrap onto low words.
  assign addr_ok  = (32'(addr) < 32'(RAM_SIZE));
  assign iaddr_ok = (32'(instraddr) < 32'(RAM_SIZE));
  assign wr_hit   = we && addr_ok;

  always_ff @(posedge clk) begin
    if (rst_n && wr_hit) begin
      mem[addr] <= datawr;
    end
  end

  // Write-first: a read of the word being written this edge returns the
  // new data on both ports rather than the stale array contents.
  always_comb begin
    datard_d = datard_q;
    if (re) begin
      if (wr_hit) begin
        datard_d = datawr;
      end else if (addr_ok) begin
        datard_d = mem[addr];
      end else begin
        datard_d = '0;
      end
    end
  end

  always_comb begin
    instrrd_d = '0;
    if (wr_hit && (instraddr == addr)) begin
      instrrd_d = datawr;
    end else if (iaddr_ok) begin
      instrrd_d = mem[instraddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      datard_q  <= '0;
      instrrd_q <= '0;
    end else begin
      datard_q  <= datard_d;
      instrrd_q <= instrrd_d;
    end
  end

  assign datard  = datard_q;
  assign instrrd = instrrd_q;

endmodule

// File: tb/tb_mcpu_ram_controller.sv
module tb_mcpu_ram_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we;
  logic [7:0] datawr;
  logic       re;
  logic [7:0] addr;
  logic [7:0] instraddr;
  logic [7:0] datard, instrrd;
  logic [7:0] datard_s, instrrd_s;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [256];

  always #5 clk = ~clk;

  mcpu_ram_controller #(.WORD_SIZE(8), .ADDR_WIDTH(8), .RAM_SIZE(256)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .datawr(datawr), .re(re),
    .addr(addr), .datard(datard), .instraddr(instraddr), .instrrd(instrrd)
  );

  // Partially populated instance: words 200..255 do not exist.
  mcpu_ram_controller #(.WORD_SIZE(8), .ADDR_WIDTH(8), .RAM_SIZE(200)) dut_s (
    .clk(clk), .rst_n(rst_n), .we(we), .datawr(datawr), .re(re),
    .addr(addr), .datard(datard_s), .instraddr(instraddr), .instrrd(instrrd_s)
  );

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] addr;
    logic [7:0] ia;
    logic [7:0] wd;
    logic [7:0] exp_dr;
    logic [7:0] exp_ir;
    logic [7:0] exp_dr_s;
    logic [7:0] exp_ir_s;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             we  re  addr   ia     wd     dr     ir     dr_s   ir_s
    vecs[0]  = '{1'b1, 1'b1, 8'h05, 8'h05, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    vecs[1]  = '{1'b1, 1'b1, 8'hFA, 8'hFA, 8'hC3, 8'hC3, 8'hC3, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 8'h05, 8'hFA, 8'h00, 8'h3C, 8'hC3, 8'h3C, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 8'hFA, 8'h05, 8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'hFA, 8'h00, 8'h3C, 8'hC3, 8'h3C, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 8'h20, 8'h05, 8'h11, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    vecs[6]  = '{1'b1, 1'b1, 8'h20, 8'h20, 8'h99, 8'h99, 8'h99, 8'h99, 8'h99};
    vecs[7]  = '{1'b0, 1'b1, 8'h20, 8'h20, 8'h00, 8'h99, 8'h99, 8'h99, 8'h99};
    vecs[8]  = '{1'b1, 1'b0, 8'h21, 8'h20, 8'h77, 8'h99, 8'h99, 8'h99, 8'h99};
    vecs[9]  = '{1'b0, 1'b1, 8'h21, 8'h21, 8'h00, 8'h77, 8'h77, 8'h77, 8'h77};
    vecs[10] = '{1'b1, 1'b1, 8'h30, 8'h21, 8'h5A, 8'h5A, 8'h77, 8'h5A, 8'h77};
    vecs[11] = '{1'b0, 1'b0, 8'h30, 8'h30, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5A};

    rst_n = 1'b0; we = 1'b0; re = 1'b0; datawr = 8'h00; addr = 8'h00; instraddr = 8'h00;
    #1;
    step();
    step();
    check("por_datard", datard, 8'h00);
    check("por_instrrd", instrrd, 8'h00);

    // Seed mem[0x10] with a known value before the reset-suppression test.
    rst_n = 1'b1; we = 1'b1; addr = 8'h10; datawr = 8'h55;
    step();

    // Reset held two cycles with a write pending: write must be dropped.
    rst_n = 1'b0; we = 1'b1; re = 1'b1; addr = 8'h10; datawr = 8'hAA; instraddr = 8'h10;
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_datard", datard, 8'h00);
      check("rst_instrrd", instrrd, 8'h00);
    end
    rst_n = 1'b1; we = 1'b0; re = 1'b1; addr = 8'h10; instraddr = 8'h10;
    step();
    check("rst_nowrite_dr", datard, 8'h55);
    check("rst_nowrite_ir", instrrd, 8'h55);

    // Fill every address with random bytes.
    we = 1'b1; re = 1'b0;
    for (int i = 0; i < 256; i++) begin
      addr = 8'(i);
      datawr = 8'($urandom_range(0, 255));
      model[i] = datawr;
      step();
    end

    // Dual-port sweep readback.
    we = 1'b0; re = 1'b1;
    for (int i = 0; i < 256; i++) begin
      addr = 8'(i);
      instraddr = 8'(i);
      step();
      check("sweep_datard", datard, model[i]);
      check("sweep_instrrd", instrrd, model[i]);
      check("sweep_datard_small", datard_s, (i < 200) ? model[i] : 8'h00);
      check("sweep_instrrd_small", instrrd_s, (i < 200) ? model[i] : 8'h00);
    end

    // Directed vector table: independence, hold, write-first bypass.
    for (int v = 0; v < 12; v++) begin
      we = vecs[v].we; re = vecs[v].re; addr = vecs[v].addr;
      instraddr = vecs[v].ia; datawr = vecs[v].wd;
      step();
      check($sformatf("vec%0d_datard", v), datard, vecs[v].exp_dr);
      check($sformatf("vec%0d_instrrd", v), instrrd, vecs[v].exp_ir);
      check($sformatf("vec%0d_datard_small", v), datard_s, vecs[v].exp_dr_s);
      check($sformatf("vec%0d_instrrd_small", v), instrrd_s, vecs[v].exp_ir_s);
    end

    // Reset mid-operation: outputs clear, contents survive.
    we = 1'b0; re = 1'b1; addr = 8'h05; instraddr = 8'hFA;
    rst_n = 1'b0;
    step();
    check("midrst_datard", datard, 8'h00);
    check("midrst_instrrd", instrrd, 8'h00);
    check("midrst_datard_small", datard_s, 8'h00);
    rst_n = 1'b1;
    step();
    check("postrst_datard", datard, 8'h3C);
    check("postrst_instrrd", instrrd, 8'hC3);
    check("postrst_datard_small", datard_s, 8'h3C);
    check("postrst_instrrd_small", instrrd_s, 8'h00);
    addr = 8'h40; instraddr = 8'h80;
    step();
    check("postrst_fill_dr", datard, model[8'h40]);
    check("postrst_fill_ir", instrrd, model[8'h80]);

    // Out-of-range write on the small instance must not alias onto low words.
    we = 1'b1; re = 1'b0; addr = 8'hD0; datawr = 8'hEE; instraddr = 8'h00;
    step();
    we = 1'b0; re = 1'b1; addr = 8'h10; instraddr = 8'hD0;
    step();
    check("oor_nowrap_dr_small", datard_s, model[8'h10]);
    check("oor_ir_small", instrrd_s, 8'h00);
    check("oor_ir_main", instrrd, 8'hEE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
